// File: rtl/phys_reg_free_list.sv
// Physical register free list.
// Keeps a bitmap of free physical tags (1 = free) and grants the lowest
// free tag, one per cycle, to rename. Retire returns tags through the free
// port. The lowest free tag is found by an LSB-first priority search built
// from 4-bit blocks. Every output is driven from a register; empty is
// decoded from the registered count.
module phys_reg_free_list #(
   parameter int WIDTH    = 64,
   parameter int RESERVED = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     alloc_req,
   output logic                     alloc_valid,
   output logic [$clog2(WIDTH)-1:0] alloc_idx,
   input  logic                     free_valid,
   input  logic [$clog2(WIDTH)-1:0] free_idx,
   output logic [$clog2(WIDTH):0]   free_count,
   output logic                     empty,
   output logic                     err
);

   localparam int IW   = $clog2(WIDTH);
   // Power-of-two padded width. Any free_idx value can index it, and it
   // splits into whole 4-bit blocks because WIDTH >= 4.
   localparam int PW   = 1 << IW;
   localparam int NBLK = PW / 4;
   localparam int CW   = IW + 1;

   // Bitmap value after reset: architectural tags are busy, the rest are free.
   function automatic logic [WIDTH-1:0] reset_map();
      logic [WIDTH-1:0] m;
      for (int i = 0; i < WIDTH; i++) begin
         m[i] = (i >= RESERVED) ? 1'b1 : 1'b0;
      end
      return m;
   endfunction

   // Index of the lowest set bit in a 4-bit block.
   function automatic logic [1:0] low4(input logic [3:0] v);
      if (v[0]) begin
         return 2'd0;
      end else if (v[1]) begin
         return 2'd1;
      end else if (v[2]) begin
         return 2'd2;
      end else begin
         return 2'd3;
      end
   endfunction

   logic [WIDTH-1:0] bitmap_r;
   logic             alloc_valid_r;
   logic [IW-1:0]    alloc_idx_r;
   logic [CW-1:0]    free_count_r;
   logic             err_r;

   logic [PW-1:0]    bitmap_pad_s;
   logic [PW-1:0]    bitmap_nx_s;
   logic [CW-1:0]    count_nx_s;
   logic [IW-1:0]    pick_idx_s;
   logic             pick_any_s;
   logic             alloc_ok_s;
   logic             free_ok_s;
   logic             free_err_s;

   // Zero-pad the bitmap so that out-of-range tags and unused blocks read as busy.
   always_comb begin
      bitmap_pad_s              = '0;
      bitmap_pad_s[WIDTH-1:0]   = bitmap_r;
   end

   // LSB-first priority search. Blocks are scanned from high to low, so the
   // lowest non-empty block is the last one to write the result.
   always_comb begin
      pick_any_s = 1'b0;
      pick_idx_s = '0;
      for (int b = NBLK - 1; b >= 0; b--) begin
         if (|bitmap_pad_s[b*4 +: 4]) begin
            pick_any_s = 1'b1;
            pick_idx_s = IW'(b * 4) + IW'(low4(bitmap_pad_s[b*4 +: 4]));
         end else begin
            pick_idx_s = pick_idx_s;
         end
      end
   end

   // Classify this cycle's requests. A free of a tag that is already free,
   // including the tag being granted right now, is a double free.
   always_comb begin
      alloc_ok_s = alloc_req & pick_any_s;
      if (free_valid) begin
         free_ok_s  = ({1'b0, free_idx} < CW'(WIDTH)) & ~bitmap_pad_s[free_idx];
         free_err_s = ~free_ok_s;
      end else begin
         free_ok_s  = 1'b0;
         free_err_s = 1'b0;
      end
   end

   // Next bitmap and count. The free is applied first so that the grant
   // clears its own bit and wins if both target the same tag.
   always_comb begin
      bitmap_nx_s = bitmap_pad_s;
      count_nx_s  = free_count_r;
      if (free_ok_s) begin
         bitmap_nx_s[free_idx] = 1'b1;
         count_nx_s            = count_nx_s + CW'(1);
      end else begin
         count_nx_s = count_nx_s;
      end
      if (alloc_ok_s) begin
         bitmap_nx_s[pick_idx_s] = 1'b0;
         count_nx_s              = count_nx_s - CW'(1);
      end else begin
         count_nx_s = count_nx_s;
      end
   end

   // State and output registers. alloc_idx holds its value when nothing is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bitmap_r      <= reset_map();
         alloc_valid_r <= 1'b0;
         alloc_idx_r   <= '0;
         free_count_r  <= CW'(WIDTH - RESERVED);
         err_r         <= 1'b0;
      end else begin
         bitmap_r      <= bitmap_nx_s[WIDTH-1:0];
         alloc_valid_r <= alloc_ok_s;
         if (alloc_ok_s) begin
            alloc_idx_r <= pick_idx_s;
         end
         free_count_r  <= count_nx_s;
         err_r         <= free_err_s;
      end
   end

   assign alloc_valid = alloc_valid_r;
   assign alloc_idx   = alloc_idx_r;
   assign free_count  = free_count_r;
   assign empty       = (free_count_r == '0);
   assign err         = err_r;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list (WIDTH=64, RESERVED=32).
// Inputs are driven on the falling edge, and outputs are sampled on the
// following falling edge, after the rising edge has taken effect.
module tb_phys_reg_free_list;

   logic       clk = 1'b0;
   logic       rst;
   logic       alloc_req;
   logic       alloc_valid;
   logic [5:0] alloc_idx;
   logic       free_valid;
   logic [5:0] free_idx;
   logic [6:0] free_count;
   logic       empty;
   logic       err;

   int checks   = 0;
   int failures = 0;

   phys_reg_free_list #(.WIDTH(64), .RESERVED(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .alloc_req   (alloc_req),
      .alloc_valid (alloc_valid),
      .alloc_idx   (alloc_idx),
      .free_valid  (free_valid),
      .free_idx    (free_idx),
      .free_count  (free_count),
      .empty       (empty),
      .err         (err)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       areq;
      logic       fv;
      logic [5:0] fidx;
      logic       av;
      logic [5:0] aidx;
      logic [6:0] cnt;
      logic       emp;
      logic       er;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs and wait until its results are visible.
   task automatic step(input logic areq, input logic fv, input logic [5:0] fidx);
      alloc_req  = areq;
      free_valid = fv;
      free_idx   = fidx;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all(input string name, input logic av, input logic [5:0] aidx,
                            input logic [6:0] cnt, input logic emp, input logic er);
      check({name, ".alloc_valid"}, 32'(alloc_valid), 32'(av));
      check({name, ".alloc_idx"},   32'(alloc_idx),   32'(aidx));
      check({name, ".free_count"},  32'(free_count),  32'(cnt));
      check({name, ".empty"},       32'(empty),       32'(emp));
      check({name, ".err"},         32'(err),         32'(er));
   endtask

   initial begin
      // Free/alloc sequences after the drain. At this point every tag is
      // busy and alloc_idx holds 63.
      //             name           areq  fv    fidx   av    aidx   cnt   emp   er
      vecs[0]  = '{"free40",      1'b0, 1'b1, 6'd40, 1'b0, 6'd63, 7'd1, 1'b0, 1'b0};
      vecs[1]  = '{"free35",      1'b0, 1'b1, 6'd35, 1'b0, 6'd63, 7'd2, 1'b0, 1'b0};
      vecs[2]  = '{"alloc35",     1'b1, 1'b0, 6'd0,  1'b1, 6'd35, 7'd1, 1'b0, 1'b0};
      vecs[3]  = '{"alloc40",     1'b1, 1'b0, 6'd0,  1'b1, 6'd40, 7'd0, 1'b1, 1'b0};
      vecs[4]  = '{"free50",      1'b0, 1'b1, 6'd50, 1'b0, 6'd40, 7'd1, 1'b0, 1'b0};
      vecs[5]  = '{"alloc_free7", 1'b1, 1'b1, 6'd7,  1'b1, 6'd50, 7'd1, 1'b0, 1'b0};
      vecs[6]  = '{"alloc7",      1'b1, 1'b0, 6'd0,  1'b1, 6'd7,  7'd0, 1'b1, 1'b0};
      vecs[7]  = '{"free45",      1'b0, 1'b1, 6'd45, 1'b0, 6'd7,  7'd1, 1'b0, 1'b0};
      vecs[8]  = '{"dblfree45",   1'b0, 1'b1, 6'd45, 1'b0, 6'd7,  7'd1, 1'b0, 1'b1};
      vecs[9]  = '{"idle_a",      1'b0, 1'b0, 6'd0,  1'b0, 6'd7,  7'd1, 1'b0, 1'b0};
      vecs[10] = '{"alloc_dbl45", 1'b1, 1'b1, 6'd45, 1'b1, 6'd45, 7'd0, 1'b1, 1'b1};
      vecs[11] = '{"idle_b",      1'b0, 1'b0, 6'd0,  1'b0, 6'd45, 7'd0, 1'b1, 1'b0};
      vecs[12] = '{"alloc_none",  1'b1, 1'b0, 6'd0,  1'b0, 6'd45, 7'd0, 1'b1, 1'b0};
      vecs[13] = '{"free3",       1'b0, 1'b1, 6'd3,  1'b0, 6'd45, 7'd1, 1'b0, 1'b0};

      rst        = 1'b1;
      alloc_req  = 1'b0;
      free_valid = 1'b0;
      free_idx   = 6'd0;
      repeat (2) @(negedge clk);
      check_all("reset", 1'b0, 6'd0, 7'd32, 1'b0, 1'b0);
      rst = 1'b0;

      // Drain: 33 consecutive requests. The first 32 are granted tags 32..63.
      for (int i = 0; i < 33; i++) begin
         step(1'b1, 1'b0, 6'd0);
         if (i < 32) begin
            check_all($sformatf("drain%0d", i), 1'b1, 6'(32 + i), 7'(31 - i), (i == 31), 1'b0);
         end else begin
            check_all("drain_end", 1'b0, 6'd63, 7'd0, 1'b1, 1'b0);
         end
      end

      // Table-driven vectors
      for (int v = 0; v < 14; v++) begin
         step(vecs[v].areq, vecs[v].fv, vecs[v].fidx);
         check_all(vecs[v].name, vecs[v].av, vecs[v].aidx, vecs[v].cnt, vecs[v].emp, vecs[v].er);
      end

      // Tag 3 was freed in the last vector, so the next request receives it.
      step(1'b1, 1'b0, 6'd0);
      check_all("alloc3", 1'b1, 6'd3, 7'd0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of streaming allocation.
      rst = 1'b1;
      step(1'b0, 1'b0, 6'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 6'd0);
         check_all($sformatf("stream%0d", i), 1'b1, 6'(32 + i), 7'(31 - i), 1'b0, 1'b0);
      end
      alloc_req = 1'b1;
      @(posedge clk);
      #2;
      check("pre_rst.alloc_valid", 32'(alloc_valid), 32'd1);
      rst = 1'b1;
      #1;
      check_all("async_rst", 1'b0, 6'd0, 7'd32, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 1'b0, 6'd0);
      check_all("post_rst", 1'b1, 6'd32, 7'd31, 1'b0, 1'b0);
      step(1'b0, 1'b0, 6'd0);
      check_all("post_rst_idle", 1'b0, 6'd32, 7'd31, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
